// File: rtl/dtm_jtag.sv
// -----------------------------------------------------------------------------
// dtm_jtag -- RISC-V style JTAG Debug Transport Module, fully clk-synchronous.
//
// The JTAG pins are oversampled by clk. tck/tms/tdi each go through a 2-flop
// synchronizer plus one history flop. A change of the synchronized tck marks a
// rise or fall event. The TAP controller, IR and DR logic advance only on
// those events. Update-DR of the DMI register launches one request on the DMI
// handshake bus. The request stays pending until the debug module returns
// dmi_ready.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   resetn     synchronous, active-low reset
//   tck/tms/tdi asynchronous JTAG inputs
//   tdo        registered JTAG output, updated on tck fall events
//   dmi_valid  request pending            dmi_ready  completion from DM
//   dmi_write  1 = write, 0 = read        dmi_addr   register address
//   dmi_wdata  write data                 dmi_rdata  read data at completion
// -----------------------------------------------------------------------------
module dtm_jtag #(
  parameter logic [31:0] IDCODE = 32'h2000_0001,
  parameter int          ABITS  = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             dmi_valid,
  input  logic             dmi_ready,
  output logic             dmi_write,
  output logic [ABITS-1:0] dmi_addr,
  output logic [31:0]      dmi_wdata,
  input  logic [31:0]      dmi_rdata
);

  localparam int          DW        = ABITS + 34;
  localparam logic [5:0]  ABITS6    = 6'(ABITS);
  localparam logic [4:0]  IR_IDCODE = 5'h01;
  localparam logic [4:0]  IR_DTMCS  = 5'h10;
  localparam logic [4:0]  IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_e;

  // Stage [1] is the synchronized value, stage [2] its one-clk history.
  logic [2:0]       tck_q, tms_q, tdi_q;
  tap_e             tap_q, tap_d;
  logic [4:0]       ir_q, ir_sr_q;
  logic [DW-1:0]    dr_q;
  logic             tdo_q;
  logic             dmi_valid_q, dmi_write_q;
  logic [ABITS-1:0] dmi_addr_q;
  logic [31:0]      dmi_wdata_q, rdata_q;
  logic [1:0]       dmistat_q;

  wire tck_rise = tck_q[1] & ~tck_q[2];
  wire tck_fall = ~tck_q[1] & tck_q[2];
  // tms/tdi are stable for several clks around a tck edge, so the history
  // stage is a safe sampling point and keeps all three paths identical.
  wire tms_s = tms_q[2];
  wire tdi_s = tdi_q[2];

  wire [31:0] dtmcs_cap = {14'h0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, ABITS6, 4'd1};
  wire [1:0]  dmi_status = (dmistat_q != 2'd0 || dmi_valid_q) ? 2'd3 : 2'd0;
  wire [1:0]  dr_op = dr_q[1:0];

  // NOTE: combinational blocks assign a default first so no path can leave
  // tap_d unassigned and infer a latch.
  always_comb begin
    tap_d = tap_q;
    case (tap_q)
      TLR:      tap_d = tms_s ? TLR      : RTI;
      RTI:      tap_d = tms_s ? SEL_DR   : RTI;
      SEL_DR:   tap_d = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_d = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_d = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_d = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_d = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_d = tms_s ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_d = tms_s ? SEL_DR   : RTI;
      SEL_IR:   tap_d = tms_s ? TLR      : CAP_IR;
      CAP_IR:   tap_d = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_d = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_d = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_d = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_d = tms_s ? UPD_IR   : SHIFT_IR;
      UPD_IR:   tap_d = tms_s ? SEL_DR   : RTI;
      default:  tap_d = TLR;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tck_q       <= '0;
      tms_q       <= '0;
      tdi_q       <= '0;
      tap_q       <= TLR;
      ir_q        <= IR_IDCODE;
      ir_sr_q     <= '0;
      dr_q        <= '0;
      tdo_q       <= 1'b0;
      dmi_valid_q <= 1'b0;
      dmi_write_q <= 1'b0;
      dmi_addr_q  <= '0;
      dmi_wdata_q <= '0;
      rdata_q     <= '0;
      dmistat_q   <= '0;
    end else begin
      tck_q <= {tck_q[1:0], tck};
      tms_q <= {tms_q[1:0], tms};
      tdi_q <= {tdi_q[1:0], tdi};

      // DMI completion. Later JTAG-side assignments below take priority.
      if (dmi_valid_q && dmi_ready) begin
        dmi_valid_q <= 1'b0;
        if (!dmi_write_q) rdata_q <= dmi_rdata;
      end

      if (tck_rise) begin
        tap_q <= tap_d;
        case (tap_q)
          CAP_IR:   ir_sr_q <= 5'b00001;
          SHIFT_IR: ir_sr_q <= {tdi_s, ir_sr_q[4:1]};
          CAP_DR: begin
            case (ir_q)
              IR_IDCODE: dr_q <= {{(DW-32){1'b0}}, IDCODE[31:1], 1'b1};
              IR_DTMCS:  dr_q <= {{(DW-32){1'b0}}, dtmcs_cap};
              IR_DMI:    dr_q <= {dmi_addr_q, rdata_q, dmi_status};
              default:   dr_q <= '0;
            endcase
          end
          SHIFT_DR: begin
            // Shift length follows the selected register: tdi enters its MSB.
            case (ir_q)
              IR_IDCODE, IR_DTMCS: dr_q <= {{(DW-32){1'b0}}, tdi_s, dr_q[31:1]};
              IR_DMI:              dr_q <= {tdi_s, dr_q[DW-1:1]};
              default:             dr_q <= {{(DW-1){1'b0}}, tdi_s};
            endcase
          end
          default: ;
        endcase
      end

      if (tck_fall) begin
        if (tap_q == SHIFT_IR) tdo_q <= ir_sr_q[0];
        if (tap_q == SHIFT_DR) tdo_q <= dr_q[0];
        if (tap_q == UPD_IR)   ir_q  <= ir_sr_q;
        if (tap_q == UPD_DR) begin
          if (ir_q == IR_DTMCS) begin
            if (dr_q[17]) begin
              dmistat_q   <= 2'd0;
              dmi_valid_q <= 1'b0;
            end else if (dr_q[16]) begin
              dmistat_q <= 2'd0;
            end
          end else if (ir_q == IR_DMI) begin
            if (dmi_valid_q) begin
              dmistat_q <= 2'd3;
            end else if (dmistat_q == 2'd0 && (dr_op == 2'd1 || dr_op == 2'd2)) begin
              dmi_addr_q  <= dr_q[DW-1:34];
              dmi_wdata_q <= dr_q[33:2];
              dmi_write_q <= (dr_op == 2'd2);
              dmi_valid_q <= 1'b1;
            end
          end
        end
      end

      // Test-Logic-Reset only touches the IR; DMI state is left alone.
      if (tap_q == TLR) ir_q <= IR_IDCODE;
    end
  end

  assign tdo       = tdo_q;
  assign dmi_valid = dmi_valid_q;
  assign dmi_write = dmi_write_q;
  assign dmi_addr  = dmi_addr_q;
  assign dmi_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_dtm_jtag.sv
// -----------------------------------------------------------------------------
// tb_dtm_jtag -- directed self-checking bench for dtm_jtag.
// JTAG is bit-banged with tck phases of 4 clk each. tms/tdi change at the
// start of the low phase. Scans return the tdo stream LSB-first.
// -----------------------------------------------------------------------------
module tb_dtm_jtag;

  localparam int ABITS = 7;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             tck = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic             tdo;
  logic             dmi_valid, dmi_ready = 1'b0, dmi_write;
  logic [ABITS-1:0] dmi_addr;
  logic [31:0]      dmi_wdata, dmi_rdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  dtm_jtag #(.IDCODE(32'h2000_0001), .ABITS(ABITS)) dut (
    .clk(clk), .resetn(resetn), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
  );

  always #5 clk = ~clk;

  // One full tck period: set tms/tdi, low 4 clk, high 4 clk, low 4 clk.
  task automatic tck_cycle(input logic t_ms, input logic t_di);
    @(negedge clk);
    tms = t_ms;
    tdi = t_di;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // From Shift-xR: shift n bits, then Exit1 -> Update -> Run-Test/Idle.
  task automatic scan(input logic [63:0] din, input int n, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tck_cycle(i == n - 1, din[i]);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    scan(din, n, dout);
  endtask

  task automatic scan_ir(input logic [4:0] ir, output logic [63:0] dout);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    scan({59'h0, ir}, 5, dout);
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return {23'h0, a, d, op};
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    n_assert++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
    n_assert++; if (dmi_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dmi_valid); end
    n_assert++; if (dmi_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b exp=0", dmi_write); end
    n_assert++; if (dmi_addr !== 7'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", dmi_addr); end
    n_assert++; if (dmi_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", dmi_wdata); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idcode;
    logic [63:0] d;
    repeat (5) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    scan_dr(64'h0, 32, d);
    n_assert++; if (d[31:0] !== 32'h2000_0001) begin n_fail++; $display("FAIL idcode got=%h exp=20000001", d[31:0]); end
  endtask

  task automatic test_dmi_write;
    logic [63:0] d;
    scan_ir(5'h11, d);
    n_assert++; if (d[4:0] !== 5'b00001) begin n_fail++; $display("FAIL ir_capture got=%b exp=00001", d[4:0]); end
    scan_dr(dmi_word(7'h10, 32'h1, 2'd2), 41, d);
    n_assert++; if (d[40:0] !== 41'h0) begin n_fail++; $display("FAIL dmi_first_capture got=%h exp=0", d[40:0]); end
    repeat (6) @(negedge clk);
    n_assert++; if (dmi_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid got=%b exp=1", dmi_valid); end
    n_assert++; if (dmi_write !== 1'b1) begin n_fail++; $display("FAIL wr_write got=%b exp=1", dmi_write); end
    n_assert++; if (dmi_addr !== 7'h10) begin n_fail++; $display("FAIL wr_addr got=%h exp=10", dmi_addr); end
    n_assert++; if (dmi_wdata !== 32'h1) begin n_fail++; $display("FAIL wr_wdata got=%h exp=1", dmi_wdata); end
    dmi_ready = 1'b1;
    @(negedge clk);
    dmi_ready = 1'b0;
    n_assert++; if (dmi_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid_drop got=%b exp=0", dmi_valid); end
  endtask

  task automatic test_dmi_read;
    logic [63:0] d;
    scan_dr(dmi_word(7'h11, 32'h0, 2'd1), 41, d);
    repeat (3) @(negedge clk);
    n_assert++; if (dmi_valid !== 1'b1 || dmi_write !== 1'b0) begin
      n_fail++; $display("FAIL rd_req got valid=%b write=%b exp valid=1 write=0", dmi_valid, dmi_write); end
    dmi_rdata = 32'h0000_0C00;
    dmi_ready = 1'b1;
    @(negedge clk);
    dmi_ready = 1'b0;
    dmi_rdata = 32'hFFFF_FFFF;
    scan_dr(dmi_word(7'h0, 32'h0, 2'd0), 41, d);
    n_assert++; if (d[33:2] !== 32'h0000_0C00) begin n_fail++; $display("FAIL rd_data got=%h exp=00000c00", d[33:2]); end
    n_assert++; if (d[1:0] !== 2'd0) begin n_fail++; $display("FAIL rd_status got=%0d exp=0", d[1:0]); end
    n_assert++; if (d[40:34] !== 7'h11) begin n_fail++; $display("FAIL rd_addr got=%h exp=11", d[40:34]); end
  endtask

  task automatic test_busy;
    logic [63:0] d;
    scan_dr(dmi_word(7'h05, 32'hDEAD_BEEF, 2'd2), 41, d);
    scan_dr(dmi_word(7'h06, 32'h0000_1234, 2'd2), 41, d);
    n_assert++; if (d[1:0] !== 2'd3) begin n_fail++; $display("FAIL busy_capture got=%0d exp=3", d[1:0]); end
    n_assert++; if (dmi_addr !== 7'h05 || dmi_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL busy_hold got addr=%h wdata=%h exp addr=05 wdata=deadbeef", dmi_addr, dmi_wdata); end
    dmi_ready = 1'b1;
    @(negedge clk);
    dmi_ready = 1'b0;
    scan_dr(dmi_word(7'h0, 32'h0, 2'd0), 41, d);
    n_assert++; if (d[1:0] !== 2'd3) begin n_fail++; $display("FAIL sticky_capture got=%0d exp=3", d[1:0]); end
    n_assert++; if (d[33:2] !== 32'h0000_0C00) begin n_fail++; $display("FAIL write_keeps_rdata got=%h exp=00000c00", d[33:2]); end
    scan_ir(5'h10, d);
    scan_dr(64'h0, 32, d);
    n_assert++; if (d[31:0] !== 32'h0000_1C71) begin n_fail++; $display("FAIL dtmcs_sticky got=%h exp=00001c71", d[31:0]); end
    scan_dr(64'h1_0000, 32, d);
    scan_dr(64'h0, 32, d);
    n_assert++; if (d[31:0] !== 32'h0000_1071) begin n_fail++; $display("FAIL dtmcs_cleared got=%h exp=00001071", d[31:0]); end
  endtask

  task automatic test_hardreset;
    logic [63:0] d;
    scan_ir(5'h11, d);
    scan_dr(dmi_word(7'h03, 32'h0000_00A5, 2'd2), 41, d);
    repeat (2) @(negedge clk);
    n_assert++; if (dmi_valid !== 1'b1) begin n_fail++; $display("FAIL hr_launch got=%b exp=1", dmi_valid); end
    scan_ir(5'h10, d);
    scan_dr(64'h2_0000, 32, d);
    n_assert++; if (d[31:0] !== 32'h0000_1071) begin n_fail++; $display("FAIL hr_dtmcs got=%h exp=00001071", d[31:0]); end
    n_assert++; if (dmi_valid !== 1'b0) begin n_fail++; $display("FAIL hr_valid got=%b exp=0", dmi_valid); end
    scan_ir(5'h11, d);
    scan_dr(dmi_word(7'h0, 32'h0, 2'd0), 41, d);
    n_assert++; if (d[1:0] !== 2'd0) begin n_fail++; $display("FAIL hr_status got=%0d exp=0", d[1:0]); end
  endtask

  task automatic test_bypass;
    logic [63:0] d;
    scan_ir(5'h1F, d);
    // Time order 1,0,1,1 -> expect 0,1,0,1 back.
    scan_dr(64'b1101, 4, d);
    n_assert++; if (d[3:0] !== 4'b1010) begin n_fail++; $display("FAIL bypass got=%b exp=1010", d[3:0]); end
  endtask

  task automatic test_reset_abandon;
    logic [63:0] d;
    scan_ir(5'h11, d);
    scan_dr(dmi_word(7'h20, 32'h0000_0055, 2'd2), 41, d);
    repeat (2) @(negedge clk);
    n_assert++; if (dmi_valid !== 1'b1) begin n_fail++; $display("FAIL abandon_launch got=%b exp=1", dmi_valid); end
    resetn = 1'b0;
    @(negedge clk);
    n_assert++; if (dmi_valid !== 1'b0) begin n_fail++; $display("FAIL abandon_valid got=%b exp=0", dmi_valid); end
    n_assert++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL abandon_tdo got=%b exp=0", tdo); end
    n_assert++; if (dmi_addr !== 7'h0 || dmi_wdata !== 32'h0) begin
      n_fail++; $display("FAIL abandon_bus got addr=%h wdata=%h exp 0", dmi_addr, dmi_wdata); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    tck_cycle(1'b0, 1'b0);
    scan_dr(64'h0, 32, d);
    n_assert++; if (d[31:0] !== 32'h2000_0001) begin n_fail++; $display("FAIL abandon_ir_idcode got=%h exp=20000001", d[31:0]); end
  endtask

  initial begin
    test_reset;
    test_idcode;
    test_dmi_write;
    test_dmi_read;
    test_busy;
    test_hardreset;
    test_bypass;
    test_reset_abandon;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
